// File: rtl/avmm_block_feeder.sv
// rtl/avmm_block_feeder.sv - Avalon-MM master feeding fixed-size blocks to an accelerator (optional FEEDER_STALL_CNT_EN stall counter)
module avmm_block_feeder #(
    parameter int DATA_W          = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int RESULT_WORDS    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              address,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic              read,
    input  logic [DATA_W-1:0] readdata,
    input  logic              waitrequest,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic [31:0]       stall_count
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WCNT_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int RCNT_W = (RESULT_WORDS > 1) ? $clog2(RESULT_WORDS) : 1;

    localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESULT_WORDS - 1);

    typedef enum logic [1:0] {
        WR  = 2'd0,
        RD  = 2'd1,
        OUT = 2'd2
    } state_t;

    // Input FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    // FSM state, counters and next-state values of the registered outputs
    state_t            state;
    state_t            state_n;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_n;
    logic [RCNT_W-1:0] rcnt;
    logic [RCNT_W-1:0] rcnt_n;
    logic              address_n;
    logic              write_n;
    logic              read_n;
    logic [DATA_W-1:0] writedata_n;
    logic              out_valid_n;
    logic [DATA_W-1:0] out_data_n;

    // Ready is based only on the current fill level, so a same-cycle pop never lets a full FIFO take a word
    assign full     = (count == FIFO_FULL);
    assign empty    = (count == '0);
    assign in_ready = !full && !reset;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    assign busy = !((state == WR) && (wcnt == '0) && !write && empty);

    // FIFO storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // State register and registered Avalon / result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WR;
            wcnt      <= '0;
            rcnt      <= '0;
            address   <= 1'b0;
            write     <= 1'b0;
            read      <= 1'b0;
            writedata <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            wcnt      <= wcnt_n;
            rcnt      <= rcnt_n;
            address   <= address_n;
            write     <= write_n;
            read      <= read_n;
            writedata <= writedata_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
        end
    end

    // Next-state logic: commands only change when no transfer is stalled, keeping them stable under waitrequest
    always_comb begin
        state_n     = state;
        wcnt_n      = wcnt;
        rcnt_n      = rcnt;
        address_n   = address;
        write_n     = write;
        read_n      = read;
        writedata_n = writedata;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        pop         = 1'b0;

        unique case (state)
            WR: begin
                if (!write) begin
                    if (!empty) begin
                        address_n   = 1'b1;
                        writedata_n = head;
                        write_n     = 1'b1;
                        pop         = 1'b1;
                    end
                end else if (!waitrequest) begin
                    if (wcnt == WCNT_LAST) begin
                        wcnt_n    = '0;
                        write_n   = 1'b0;
                        address_n = 1'b0;
                        read_n    = 1'b1;
                        state_n   = RD;
                    end else begin
                        wcnt_n = wcnt + WCNT_W'(1);
                        if (!empty) begin
                            writedata_n = head;
                            pop         = 1'b1;
                        end else begin
                            write_n = 1'b0;
                        end
                    end
                end
            end
            RD: begin
                if (read && !waitrequest) begin
                    out_data_n  = readdata;
                    out_valid_n = 1'b1;
                    read_n      = 1'b0;
                    state_n     = OUT;
                end
            end
            OUT: begin
                // read stays low here for at least one cycle, giving the idle gap between reads
                if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    if (rcnt == RCNT_LAST) begin
                        rcnt_n    = '0;
                        address_n = 1'b1;
                        state_n   = WR;
                    end else begin
                        rcnt_n  = rcnt + RCNT_W'(1);
                        read_n  = 1'b1;
                        state_n = RD;
                    end
                end
            end
            default: begin
                state_n = WR;
            end
        endcase
    end

`ifdef FEEDER_STALL_CNT_EN
    // Saturating count of cycles where an issued command is stalled by the slave
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if ((write || read) && waitrequest && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_avmm_block_feeder.sv
// tb/tb_avmm_block_feeder.sv - directed self-checking bench for avmm_block_feeder
module tb_avmm_block_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic [31:0] stall_count;

`ifdef FEEDER_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    int passed = 0;
    int total  = 0;
    int n;
    int base;
    int rd_base;
    int cyc = 0;

    logic [31:0] rd_resp [8];
    logic [2:0]  rd_idx = '0;

    logic [31:0] wr_log [$];
    int          wr_cyc [$];
    logic        wr_addr [$];
    logic        rd_addr_log [$];
    logic [31:0] out_log [$];

    avmm_block_feeder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .address     (address),
        .write       (write),
        .writedata   (writedata),
        .read        (read),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    // Zero-latency slave read data: one response per accepted read
    assign readdata = rd_resp[rd_idx];
    always @(posedge clk) begin
        if (read && !waitrequest) begin
            rd_idx <= rd_idx + 3'd1;
        end
    end

    // Transfer monitor, sampled mid-cycle after stimulus has settled
    always @(negedge clk) begin
        #1;
        cyc++;
        if (!reset) begin
            if (write && !waitrequest) begin
                wr_log.push_back(writedata);
                wr_cyc.push_back(cyc);
                wr_addr.push_back(address);
            end
            if (read && !waitrequest) begin
                rd_addr_log.push_back(address);
            end
            if (out_valid && out_ready) begin
                out_log.push_back(out_data);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic push_word(input logic [31:0] d);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("push_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rd_resp[0] = 32'hDEADBEEF;
        rd_resp[1] = 32'hCAFEF00D;
        rd_resp[2] = 32'h11112222;
        rd_resp[3] = 32'h33334444;
        for (int i = 4; i < 8; i++) rd_resp[i] = 32'h55550000 + i;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; waitrequest = 1'b0; out_ready = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_write", write, 1'b0);
        check("rst_read", read, 1'b0);
        check("rst_address", address, 1'b0);
        check("rst_writedata", writedata, 32'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_stall", stall_count, 32'h0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1'b1);

        // one full block with no stalls
        for (int i = 1; i <= 4; i++) push_word(i);
        n = 0;
        while (out_log.size() < 2 && n < 100) begin @(negedge clk); n++; end
        check("t1_nout", out_log.size(), 2);
        check("t1_nwr", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t1_wdata", wr_log[i], i + 1);
            check("t1_waddr", wr_addr[0] & wr_addr[3], 1'b1);
            check("t1_b2b", wr_cyc[3] - wr_cyc[0], 3);
        end
        check("t1_nrd", rd_addr_log.size(), 2);
        if (rd_addr_log.size() == 2) check("t1_raddr", rd_addr_log[0] | rd_addr_log[1], 1'b0);
        if (out_log.size() == 2) begin
            check("t1_out0", out_log[0], 32'hDEADBEEF);
            check("t1_out1", out_log[1], 32'hCAFEF00D);
        end
        @(negedge clk);
        check("t1_idle", busy, 1'b0);

        // write stalled three cycles
        base = wr_log.size();
        waitrequest = 1'b1;
        push_word(32'h89ABCDEF);
        n = 0;
        while (!write && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 4; i++) begin
            check("t2_write_held", write, 1'b1);
            check("t2_data_held", writedata, 32'h89ABCDEF);
            if (i == 3) waitrequest = 1'b0;
            @(negedge clk);
        end
        check("t2_one_word", wr_log.size() - base, 1);
        check("t2_write_drop", write, 1'b0);
        check("t2_wcnt_adv", busy, 1'b1);

        // finish the block, then two read stalls and a held result
        for (int i = 0; i < 3; i++) push_word(32'h10 + i);
        n = 0;
        while (!read && n < 20) begin @(negedge clk); n++; end
        check("t4_read_up", read, 1'b1);
        check("t4_read_addr", address, 1'b0);
        waitrequest = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("t4_read_held", read, 1'b1);
        @(negedge clk);
        waitrequest = 1'b0;
        @(negedge clk);
        check("t4_out_valid", out_valid, 1'b1);
        check("t4_out_data", out_data, 32'h11112222);
        check("t4_read_drop", read, 1'b0);
        check("stall_count", stall_count, EXP_STALL);
        rd_base = rd_addr_log.size();
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", out_valid, 1'b1);
            check("t4_hold_data", out_data, 32'h11112222);
            check("t4_hold_noread", read, 1'b0);
            @(negedge clk);
        end
        check("t4_no_read", rd_addr_log.size() - rd_base, 0);
        out_ready = 1'b1;
        n = 0;
        while (out_log.size() < 4 && n < 100) begin @(negedge clk); n++; end
        check("t4_nout", out_log.size(), 4);
        if (out_log.size() == 4) check("t4_out3", out_log[3], 32'h33334444);
        check("t4_nwr", wr_log.size(), 8);
        if (wr_log.size() == 8) begin
            check("t4_w4", wr_log[4], 32'h89ABCDEF);
            check("t4_w7", wr_log[7], 32'h12);
        end

        // fill the FIFO behind a stalled write
        do_reset();
        wr_log.delete(); wr_cyc.delete(); wr_addr.delete(); rd_addr_log.delete(); out_log.delete();
        waitrequest = 1'b1;
        for (int i = 0; i < 9; i++) push_word(32'hA0 + i);
        in_valid = 1'b1;
        in_data = 32'hA9;
        for (int i = 0; i < 3; i++) begin
            check("t3_full", in_ready, 1'b0);
            check("t3_head", writedata, 32'hA0);
            check("t3_write", write, 1'b1);
            @(negedge clk);
        end
        waitrequest = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (wr_log.size() < 10 && n < 200) begin @(negedge clk); n++; end
        check("t3_nwr", wr_log.size(), 10);
        if (wr_log.size() == 10) begin
            for (int i = 0; i < 10; i++) check("t3_order", wr_log[i], 32'hA0 + i);
        end

        // reset during the third write discards the partial block
        do_reset();
        for (int i = 0; i < 3; i++) push_word(32'hB0 + i);
        n = 0;
        while (!(write && writedata == 32'hB2) && n < 20) begin @(negedge clk); n++; end
        check("t5_third", writedata, 32'hB2);
        reset = 1'b1;
        @(negedge clk);
        check("t5_write", write, 1'b0);
        check("t5_read", read, 1'b0);
        check("t5_in_ready", in_ready, 1'b0);
        check("t5_out_valid", out_valid, 1'b0);
        reset = 1'b0;
        wr_log.delete(); out_log.delete();
        @(negedge clk);
        check("t5_idle", busy, 1'b0);
        for (int i = 0; i < 4; i++) push_word(32'hC0 + i);
        n = 0;
        while (out_log.size() < 2 && n < 100) begin @(negedge clk); n++; end
        check("t5_nout", out_log.size(), 2);
        check("t5_nwr", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t5_wdata", wr_log[i], 32'hC0 + i);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/avmm_block_feeder.md
Name: avmm_block_feeder

Overview:
- Upstream Avalon-MM master that drives the accelerator's slave port (address, write, writedata, read, readdata, waitrequest).
- Buffers 32-bit input words from a valid/ready stream in a small FIFO.
- Writes each block of WORDS_PER_BLOCK words to accelerator address 1, then reads RESULT_WORDS results from address 0.
- Presents each result on a valid/ready output stream to the downstream consumer.

Parameters:
- DATA_W, 32, width of stream and Avalon data.
- FIFO_DEPTH, 8, input FIFO entries; power of 2, >=2.
- WORDS_PER_BLOCK, 4, writes issued per block; >=1.
- RESULT_WORDS, 2, reads issued per block; >=1.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input word valid.
- in_data  in  DATA_W  input word.
- in_ready  out  1  FIFO can accept.
- address  out  1  Avalon address: 1 = data write, 0 = result read.
- write  out  1  Avalon write request.
- writedata  out  DATA_W  Avalon write data.
- read  out  1  Avalon read request.
- readdata  in  DATA_W  Avalon read data, valid in the accept cycle (no read latency).
- waitrequest  in  1  slave stall.
- out_valid  out  1  result valid.
- out_data  out  DATA_W  result word.
- out_ready  in  1  downstream accepts.
- busy  out  1  high in any state other than WR with word count 0, write=0 and FIFO empty.
- stall_count  out  32  waitrequest stall cycles (see Optional Feature).

Behaviour:
- Reset values: address, write, read, writedata, out_valid, out_data, stall_count = 0; FIFO empty; counters 0; state WR.
- in_ready = !full && !reset. Push on in_valid && in_ready. Push into a full FIFO is impossible (ready low even if a pop occurs that cycle). Pop only when non-empty. Simultaneous push+pop keeps count.
- Avalon rule:
  - A transfer completes on a cycle where the command is high and waitrequest is low.
  - While waitrequest is high, the command, address and writedata are held stable.
  - write and read are never high together.
- All Avalon outputs are registered.
- FSM states: WR, RD, OUT.
- WR (address = 1):
  - If write = 0 and FIFO non-empty: load the FIFO head into writedata, set write = 1, pop.
  - If write = 1 and waitrequest = 0: wcnt++.
    - If wcnt was WORDS_PER_BLOCK-1: wcnt = 0, write = 0, address = 0, read = 1, go to RD.
    - Else if FIFO non-empty: load the next word immediately, keeping write = 1 (back-to-back writes, 1 word/cycle).
    - Else: write = 0.
- RD:
  - On read && !waitrequest: out_data = readdata, out_valid = 1, read = 0, go to OUT.
- OUT:
  - Hold out_valid and out_data until out_ready.
  - On out_valid && out_ready: out_valid = 0, rcnt++.
    - If rcnt was RESULT_WORDS-1: rcnt = 0, address = 1, go to WR.
    - Else: read = 1, go to RD.
  - Minimum one idle Avalon cycle between consecutive reads.
- The FIFO continues accepting input in every state.
- Counter widths are clog2 of their limits. Wrap occurs only via the explicit terminal-count clears above.
- Reset mid-operation: on the next edge write and read drop, the FIFO and counters clear, and any partial block is discarded. The next block restarts at word 0.

Optional Feature:
- Macro FEEDER_STALL_CNT_EN.
- Defined: stall_count increments (saturating at 0xFFFFFFFF) every cycle where (write || read) && waitrequest. Cleared only by reset.
- Undefined: no counter logic; stall_count tied to 0.

Test Plan:
- Push 0x00000001..0x00000004 with waitrequest=0; readdata 0xDEADBEEF then 0xCAFEF00D; out_ready=1 -> four consecutive write cycles at address 1 with data 1,2,3,4. Then two reads at address 0. out_data = 0xDEADBEEF, then 0xCAFEF00D.
- waitrequest high 3 cycles while writedata = 0x89ABCDEF -> write and data stable 4 cycles; exactly one word consumed; wcnt advances once.
- waitrequest held high; push 10 words -> word 1 sits in writedata, 8 fill the FIFO, in_ready=0 for the 10th; after release the words drain in order.
- Result ready, out_ready low 5 cycles -> out_valid and out_data held; no second read until the handshake.
- Assert reset during the 3rd write -> next cycle write=0, in_ready=0, out_valid=0. After release the block restarts; a fresh 4 words produce 4 writes.
- With FEEDER_STALL_CNT_EN defined: 3 write stalls + 2 read stalls -> stall_count = 5. Undefined -> 0.
